// File: rtl/core8_mem_copy_engine.sv
// core8_mem_copy_engine
//
// Copy/fill engine that is the only master of one per-core on-chip memory
// (2^ADDR_W x 32, single-port, byte-enabled, registered address / unregistered
// read data). A processor programs SRC/DST/LEN/PATTERN/CTRL through a small CSR
// slave. The engine then copies words inside the memory (RD/WR pairs) or fills
// a region with PATTERN (one WR per cycle), and reports completion through
// STATUS.DONE and a level interrupt.
//
// Ports:
//   clk, reset_n                      clock, synchronous active-low reset
//   csr_address/read/write/writedata  CSR slave request (word offsets 0..7)
//   csr_readdata                      CSR read data, registered, latency 1
//   irq                               done & irq_en
//   mem_address/chipselect/write      memory master request
//   mem_byteenable, mem_clken         constant 4'hF and 1
//   mem_writedata                     read data (copy) or PATTERN (fill)
//   mem_readdata                      memory data, valid the cycle after RD
//
// CSR map: 0 SRC, 1 DST, 2 LEN, 3 CTRL {IRQ_EN, ABORT, FILL, GO},
//          4 STATUS {remaining[31:16], ABORTED, DONE, BUSY}, 5 PATTERN.
module core8_mem_copy_engine #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned LEN_W  = 14
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        csr_address,
  input  logic              csr_read,
  input  logic              csr_write,
  input  logic [31:0]       csr_writedata,
  output logic [31:0]       csr_readdata,
  output logic              irq,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata,
  output logic              mem_clken
);

  typedef enum logic [1:0] {StIdle, StRd, StWr} state_e;

  localparam logic [2:0] AddrSrc    = 3'd0;
  localparam logic [2:0] AddrDst    = 3'd1;
  localparam logic [2:0] AddrLen    = 3'd2;
  localparam logic [2:0] AddrCtrl   = 3'd3;
  localparam logic [2:0] AddrStatus = 3'd4;
  localparam logic [2:0] AddrPat    = 3'd5;

  state_e state_q, state_d;

  // Programmed registers
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [LEN_W-1:0]  len_q;
  logic [31:0]       pattern_q;
  logic              fill_q, irq_en_q;
  logic              done_q, aborted_q;

  // Working copies used while a transfer runs
  logic [ADDR_W-1:0] wsrc_q, wdst_q;
  logic [LEN_W-1:0]  cnt_q;

  logic [31:0] readdata_q;
  logic [31:0] rdata_mux;

  logic busy;
  logic ctrl_wr, status_wr;
  logic go_req, start, zero_go, abort_req, last_wr;

  assign busy      = (state_q != StIdle);
  assign ctrl_wr   = csr_write && (csr_address == AddrCtrl);
  assign status_wr = csr_write && (csr_address == AddrStatus);
  assign go_req    = ctrl_wr && csr_writedata[0] && !busy;
  assign start     = go_req && (len_q != '0);
  assign zero_go   = go_req && (len_q == '0);
  assign abort_req = ctrl_wr && csr_writedata[2] && busy;
  assign last_wr   = (state_q == StWr) && (cnt_q == LEN_W'(1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. ABORT lets the current RD/WR cycle complete, then idles.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        // FILL is written in the same CTRL write as GO, so use the write data.
        if (start) begin
          state_d = csr_writedata[1] ? StWr : StRd;
        end
      end
      StRd: begin
        state_d = abort_req ? StIdle : StWr;
      end
      StWr: begin
        if (last_wr || abort_req) begin
          state_d = StIdle;
        end else begin
          state_d = fill_q ? StWr : StRd;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: memory-side outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_writedata  = '0;
    unique case (state_q)
      StRd: begin
        mem_chipselect = 1'b1;
        mem_address    = wsrc_q;
      end
      StWr: begin
        mem_chipselect = 1'b1;
        mem_write      = 1'b1;
        mem_address    = wdst_q;
        // Read data here belongs to the address presented in the preceding RD.
        mem_writedata  = fill_q ? pattern_q : mem_readdata;
      end
      default: ;
    endcase
  end

  assign mem_byteenable = 4'hF;
  assign mem_clken      = 1'b1;

  // ---------------------------------------------------------------------------
  // CSR read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata_mux = '0;
    unique case (csr_address)
      AddrSrc:    rdata_mux = 32'(src_q);
      AddrDst:    rdata_mux = 32'(dst_q);
      AddrLen:    rdata_mux = 32'(len_q);
      AddrCtrl:   rdata_mux = {28'd0, irq_en_q, 1'b0, fill_q, 1'b0};
      AddrStatus: rdata_mux = {16'(cnt_q), 13'd0, aborted_q, done_q, busy};
      AddrPat:    rdata_mux = pattern_q;
      default:    rdata_mux = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers, working counters and status
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      pattern_q  <= '0;
      fill_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      wsrc_q     <= '0;
      wdst_q     <= '0;
      cnt_q      <= '0;
      readdata_q <= '0;
    end else begin
      // Transfer parameters are frozen while busy.
      if (csr_write && !busy) begin
        unique case (csr_address)
          AddrSrc: src_q     <= csr_writedata[ADDR_W-1:0];
          AddrDst: dst_q     <= csr_writedata[ADDR_W-1:0];
          AddrLen: len_q     <= csr_writedata[LEN_W-1:0];
          AddrPat: pattern_q <= csr_writedata;
          default: ;
        endcase
      end
      if (ctrl_wr) begin
        irq_en_q <= csr_writedata[3];
        if (!busy) begin
          fill_q <= csr_writedata[1];
        end
      end

      // Write-1-to-clear first; any set later in this block wins.
      if (status_wr) begin
        if (csr_writedata[1]) done_q    <= 1'b0;
        if (csr_writedata[2]) aborted_q <= 1'b0;
      end

      if (start) begin
        wsrc_q    <= src_q;
        wdst_q    <= dst_q;
        cnt_q     <= len_q;
        done_q    <= 1'b0;
        aborted_q <= 1'b0;
      end

      if (zero_go) begin
        done_q    <= 1'b1;
        aborted_q <= 1'b0;
      end

      if (state_q == StWr) begin
        wsrc_q <= wsrc_q + ADDR_W'(1);
        wdst_q <= wdst_q + ADDR_W'(1);
        cnt_q  <= cnt_q - LEN_W'(1);
      end

      // An abort landing on the final WR is moot: the transfer completed.
      if (last_wr) begin
        done_q <= 1'b1;
      end else if (abort_req) begin
        aborted_q <= 1'b1;
      end

      if (csr_read) begin
        readdata_q <= rdata_mux;
      end
    end
  end

  assign csr_readdata = readdata_q;
  assign irq          = done_q & irq_en_q;

endmodule
